// File: rtl/fifo_write_arbiter.sv
// Round-robin packet arbiter in front of a FIFO write port: grants a whole
// burst to one requester only when the FIFO has room for every beat of it.
module fifo_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 6,
    parameter int FIFODEPTH = 44,
    parameter int LENWIDTH  = 4
) (
    input  logic                      w_clk,
    input  logic                      w_rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*LENWIDTH-1:0]  req_len,
    input  logic [NREQ*DATAWIDTH-1:0] req_data,
    input  logic                      w_full,
    input  logic [ADDRWIDTH:0]        w_counter,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           beat_ack,
    output logic                      w_en,
    output logic [DATAWIDTH-1:0]      w_data,
    output logic                      busy
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Wide enough that occupancy plus a full burst can never wrap.
    localparam int CW   = (ADDRWIDTH + 2 > LENWIDTH + 2) ? ADDRWIDTH + 2 : LENWIDTH + 2;

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              state_q,  state_d;
    logic [IDXW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]     owner_q,  owner_d;
    logic [LENWIDTH-1:0] len_q,    len_d;
    logic [LENWIDTH-1:0] beat_q,   beat_d;
    logic [NREQ-1:0]     gnt_q,    gnt_d;
    logic                busy_q,   busy_d;

    logic                found;
    logic [IDXW-1:0]     winner;
    logic [IDXW:0]       probe;
    logic [LENWIDTH-1:0] winner_len;
    logic [CW-1:0]       need;
    logic                space_ok;

    // Round-robin search: first asserted request at or after rr_ptr, wrapping.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        found  = 1'b0;
        winner = rr_ptr_q;
        probe  = '0;
        for (int k = 0; k < NREQ; k++) begin
            probe = {1'b0, rr_ptr_q} + (IDXW+1)'(k);
            if (probe >= (IDXW+1)'(NREQ)) begin
                probe = probe - (IDXW+1)'(NREQ);
            end
            if (!found && req[probe[IDXW-1:0]]) begin
                found  = 1'b1;
                winner = probe[IDXW-1:0];
            end
        end
    end

    // The winner is held (never skipped) until the whole packet fits.
    always_comb begin
        winner_len = req_len[int'(winner)*LENWIDTH +: LENWIDTH];
        need       = CW'(w_counter) + CW'(winner_len) + CW'(1);
        space_ok   = (need <= CW'(FIFODEPTH));
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        len_d    = len_q;
        beat_d   = beat_q;
        gnt_d    = gnt_q;
        busy_d   = busy_q;
        case (state_q)
            ARB: begin
                if (found && space_ok) begin
                    state_d = BURST;
                    owner_d = winner;
                    len_d   = winner_len;
                    beat_d  = '0;
                    gnt_d   = NREQ'(1) << winner;
                    busy_d  = 1'b1;
                end
            end
            BURST: begin
                if (w_en) begin
                    if (beat_q == len_q) begin
                        state_d  = ARB;
                        beat_d   = '0;
                        gnt_d    = '0;
                        busy_d   = 1'b0;
                        rr_ptr_d = (owner_q == IDXW'(NREQ-1)) ? '0 : owner_q + 1'b1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    // A full FIFO simply withholds the beat; the requester keeps presenting it.
    always_comb begin
        w_en     = 1'b0;
        w_data   = '0;
        beat_ack = '0;
        if (state_q == BURST) begin
            w_en     = !w_full;
            w_data   = req_data[int'(owner_q)*DATAWIDTH +: DATAWIDTH];
            beat_ack = w_en ? (NREQ'(1) << owner_q) : '0;
        end
    end

    always_ff @(posedge w_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!w_rst_n) begin
            state_q  <= ARB;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
        end
    end

    assign gnt  = gnt_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios with literal expectations,
// then random requester traffic checked every cycle against a packet-level model.
module tb_fifo_write_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 44;
    localparam int LW    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*LW-1:0] req_len;
    logic [NREQ*DW-1:0] req_data;
    logic              w_full;
    logic [AW:0]       w_counter;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   beat_ack;
    logic              w_en;
    logic [DW-1:0]     w_data;
    logic              busy;

    fifo_write_arbiter #(
        .NREQ(NREQ), .DATAWIDTH(DW), .ADDRWIDTH(AW), .FIFODEPTH(DEPTH), .LENWIDTH(LW)
    ) dut (
        .w_clk(clk), .w_rst_n(rst_n), .req(req), .req_len(req_len),
        .req_data(req_data), .w_full(w_full), .w_counter(w_counter),
        .gnt(gnt), .beat_ack(beat_ack), .w_en(w_en), .w_data(w_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Packet-level model: who owns the FIFO and how many beats remain.
    bit              m_busy = 1'b0;
    int              m_owner = 0;
    int              m_left = 0;
    int              m_ptr = 0;
    logic [NREQ-1:0] m_ack = '0;
    bit              m_rst_seen = 1'b0;

    int              a_len [NREQ];
    int              a_idx [NREQ];
    logic [DW-1:0]   a_data [NREQ][16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // One clock: compare outputs mid-cycle, then advance the model on the edge.
    task automatic cycle();
        logic [NREQ-1:0] e_gnt;
        logic            e_wen;
        logic [DW-1:0]   e_data;
        int              len;
        @(negedge clk);
        e_gnt  = m_busy ? (NREQ'(1) << m_owner) : '0;
        e_wen  = m_busy && !w_full;
        e_data = m_busy ? req_data[m_owner*DW +: DW] : '0;
        m_ack  = e_wen ? e_gnt : '0;
        check("gnt",      32'(gnt),      32'(e_gnt));
        check("busy",     32'(busy),     32'(m_busy));
        check("w_en",     32'(w_en),     32'(e_wen));
        check("beat_ack", 32'(beat_ack), 32'(m_ack));
        check("w_data",   32'(w_data),   32'(e_data));
        @(posedge clk);
        m_rst_seen = !rst_n;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_ptr  = 0;
            m_left = 0;
        end else if (m_busy) begin
            if (!w_full) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_owner + 1) % NREQ;
                end
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (req[i]) begin
                    len = int'(req_len[i*LW +: LW]);
                    if (DEPTH - int'(w_counter) >= len + 1) begin
                        m_busy  = 1'b1;
                        m_owner = i;
                        m_left  = len + 1;
                    end
                    break;
                end
            end
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb;
        int it;
        logic [NREQ-1:0] fair_order [5];
        fair_order[0] = 4'b0001; fair_order[1] = 4'b0010; fair_order[2] = 4'b0100;
        fair_order[3] = 4'b1000; fair_order[4] = 4'b0001;
        for (int i = 0; i < NREQ; i++) begin
            a_len[i] = 0;
            a_idx[i] = 0;
        end

        rst_n = 1'b0; req = '0; req_len = '0; req_data = '0; w_full = 1'b0; w_counter = '0;
        cycle();
        cycle();
        check("rst_gnt",  32'(gnt),  32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_wen",  32'(w_en), 32'h0);
        rst_n = 1'b1;

        // Single 4-beat packet from requester 0.
        req = 4'b0001; req_len[3:0] = 4'd3; req_data[7:0] = 8'hA0;
        cycle();
        check("single_gnt",  32'(gnt),  32'h1);
        check("single_busy", 32'(busy), 32'h1);
        for (int b = 0; b < 4; b++) begin
            req_data[7:0] = 8'(8'hA0 + b);
            #1;
            check("single_wen",  32'(w_en),     32'h1);
            check("single_ack",  32'(beat_ack), 32'h1);
            check("single_data", 32'(w_data),   32'(8'(8'hA0 + b)));
            cycle();
        end
        check("single_end_gnt",  32'(gnt),  32'h0);
        check("single_end_busy", 32'(busy), 32'h0);
        req = '0;
        cycle();

        // Fairness with all four requesting single-beat packets.
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        req = 4'b1111; req_len = '0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("fair_gnt", 32'(gnt), 32'(fair_order[k]));
            cycle();
            check("fair_gap_gnt", 32'(gnt),  32'h0);
            check("fair_gap_wen", 32'(w_en), 32'h0);
        end
        req = '0;
        cycle();

        // Space check: 42 used leaves 2, a 4-beat packet must wait.
        req = 4'b0010; req_len[7:4] = 4'd3; req_data[15:8] = 8'h5A; w_counter = 7'd42;
        repeat (3) begin
            cycle();
            check("space_hold", 32'(gnt), 32'h0);
        end
        w_counter = 7'd40;
        cycle();
        check("space_gnt", 32'(gnt), 32'h2);
        w_counter = 7'd60;
        #1;
        check("space_ignore_wen", 32'(w_en), 32'h1);
        repeat (4) cycle();
        check("space_end_busy", 32'(busy), 32'h0);
        req = '0; w_counter = '0;
        cycle();

        // Stall: 6-beat packet with w_full for two cycles mid-burst.
        req = 4'b1000; req_len[15:12] = 4'd5;
        cycle();
        check("stall_gnt", 32'(gnt), 32'h8);
        nb = 0;
        it = 0;
        while (busy && it < 20) begin
            w_full = (it == 2 || it == 3);
            req_data[31:24] = 8'(8'h30 + nb);
            #1;
            if (w_full) begin
                check("stall_wen", 32'(w_en),     32'h0);
                check("stall_ack", 32'(beat_ack), 32'h0);
            end else if (beat_ack[3]) begin
                check("stall_data", 32'(w_data), 32'(8'(8'h30 + nb)));
                nb++;
            end
            cycle();
            it++;
        end
        w_full = 1'b0;
        check("stall_beats", 32'(nb), 32'd6);
        check("stall_busy",  32'(busy), 32'h0);
        req = '0;
        cycle();

        // Reset in the middle of a 4-beat packet.
        req = 4'b0100; req_len[11:8] = 4'd3; req_data[23:16] = 8'h77;
        cycle();
        check("mrst_gnt", 32'(gnt), 32'h4);
        cycle();
        cycle();
        rst_n = 1'b0;
        cycle();
        check("mrst_gnt_clr",  32'(gnt),  32'h0);
        check("mrst_busy_clr", 32'(busy), 32'h0);
        #1;
        check("mrst_wen_clr", 32'(w_en), 32'h0);
        rst_n = 1'b1;
        cycle();
        check("mrst_regrant", 32'(gnt), 32'h4);
        repeat (4) cycle();
        check("mrst_end_busy", 32'(busy), 32'h0);
        req = '0;
        cycle();

        // Random traffic: requesters hold each packet until its last beat.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (m_rst_seen) begin
                        a_idx[i] = 0;
                    end else if (m_ack[i]) begin
                        a_idx[i]++;
                        if (a_idx[i] > a_len[i]) req[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    a_len[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                                           : int'($urandom_range(0, 3));
                    for (int b = 0; b < 16; b++) a_data[i][b] = 8'($urandom);
                    a_idx[i] = 0;
                    req[i]   = 1'b1;
                end
                req_len[i*LW +: LW]  = LW'(a_len[i]);
                req_data[i*DW +: DW] = req[i] ? a_data[i][a_idx[i]] : '0;
            end
            w_full    = ($urandom_range(0, 3) == 0);
            w_counter = 7'($urandom_range(0, 50));
            rst_n     = ($urandom_range(0, 199) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters.
REQ-002 SHALL have parameter DATAWIDTH, default 8, FIFO word width.
REQ-003 SHALL have parameter ADDRWIDTH, default 6, FIFO address width; count ports are ADDRWIDTH+1 bits.
REQ-004 SHALL have parameter FIFODEPTH, default 44, FIFO capacity in words.
REQ-005 SHALL have parameter LENWIDTH, default 4, burst-length field width.
REQ-006 SHALL have port w_clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port w_rst_n  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port req  input  NREQ  per-requester packet request, held until the last beat_ack.
REQ-009 SHALL have port req_len  input  NREQ*LENWIDTH  per-requester beats minus 1; slice i = bits [i*LENWIDTH +: LENWIDTH].
REQ-010 SHALL have port req_data  input  NREQ*DATAWIDTH  per-requester current beat data, held until beat_ack.
REQ-011 SHALL have port w_full  input  1  FIFO write-side full flag.
REQ-012 SHALL have port w_counter  input  ADDRWIDTH+1  FIFO write-side occupancy.
REQ-013 SHALL have port gnt  output  NREQ  one-hot grant, registered.
REQ-014 SHALL have port beat_ack  output  NREQ  one-hot, beat accepted this cycle.
REQ-015 SHALL have port w_en  output  1  FIFO write enable.
REQ-016 SHALL have port w_data  output  DATAWIDTH  FIFO write data.
REQ-017 SHALL have port busy  output  1  burst in progress.

Function
REQ-018 SHALL implement two states: ARB and BURST.
REQ-019 In ARB, SHALL select the winner as the first i with req[i]=1, searching round-robin from pointer rr_ptr upward, modulo NREQ.
REQ-020 SHALL grant the winner only if FIFODEPTH - w_counter >= req_len[winner] + 1, computed at ADDRWIDTH+2 bits without overflow.
REQ-021 If the winner lacks space, SHALL stay in ARB holding the same winner and SHALL NOT skip to another requester (no starvation of long packets).
REQ-022 On grant, SHALL at the next edge set gnt[winner]=1, busy=1, latch len and winner, clear the beat counter, and enter BURST; the first w_en occurs the cycle after req is sampled.
REQ-023 In BURST, SHALL drive w_en = !w_full, w_data = req_data slice of the granted requester, and beat_ack[granted] = w_en.
REQ-024 SHALL increment the beat counter on each cycle where w_en=1; w_full stalls without losing or repeating beats.
REQ-025 On the beat where the count equals latched len, SHALL at the next edge clear gnt and busy, return to ARB, and set rr_ptr = (granted+1) mod NREQ.
REQ-026 SHALL ignore req, req_len, and w_counter changes during BURST; a new arbitration happens only in ARB.
REQ-027 Outside BURST, SHALL hold w_en=0, beat_ack=0, and w_data=0.
REQ-028 Consecutive packets SHALL have a minimum gap of one ARB cycle with w_en=0.
REQ-029 req_len=0 SHALL mean a 1-beat packet; maximum 2^LENWIDTH beats.

Reset
REQ-030 While w_rst_n=0 at a rising edge, SHALL set state=ARB, rr_ptr=0, gnt=0, busy=0, and the beat counter to 0; w_en, beat_ack, and w_data are therefore 0.
REQ-031 Reset mid-burst SHALL abandon the packet with no further w_en; the requester restarts the packet from beat 0.

Verification
REQ-032 Single packet: req[0]=1, len=3, w_counter=0 -> gnt[0] next cycle, four consecutive w_en/beat_ack[0], then gnt=0 and busy=0.
REQ-033 Fairness: req=4'b1111, all len=0, continuous -> grants in order 0,1,2,3,0 with one idle cycle between grants.
REQ-034 Space check: w_counter=42, req[1]=1, len=3 -> no grant; w_counter falls to 40 -> gnt[1] next cycle.
REQ-035 Stall: w_full=1 for 2 cycles mid-burst of len=5 -> w_en=0 and no beat_ack for those cycles; exactly 6 beats total, data in order.
REQ-036 Mid-burst reset: w_rst_n=0 on beat 2 of 4 -> next cycle gnt=0, w_en=0, busy=0; after release, req[2] is served first from rr_ptr=0 if req[0], req[1]=0.
